// File: rtl/pending_priority_encoder.sv
// rtl/pending_priority_encoder.sv - captures request events and emits one priority-encoded index per handshake
module pending_priority_encoder #(
  parameter int  N        = 8,
  parameter bit  PRIO_LSB = 1'b1,
  parameter bit  EDGE     = 1'b1,
  localparam int W        = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] d,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         overflow
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t       state;
  logic [N-1:0] d_q;
  logic [N-1:0] cap;
  logic         load;
  logic [W-1:0] prio_idx;
  logic [N-1:0] load_mask;
  logic [N-1:0] pending_next;
  logic         overflow_next;

  // Previous sample of d; tracked regardless of en so enabling never fakes an edge
  always_ff @(posedge clk) begin
    if (rst) d_q <= '0;
    else     d_q <= d;
  end

  // Capture vector: rising edges or levels, gated by en
  always_comb begin
    cap = '0;
    if (en) cap = EDGE ? (d & ~d_q) : d;
  end

  // Priority select: the last assignment in the scan wins, so scan away from the winning end
  always_comb begin
    prio_idx = '0;
    if (PRIO_LSB) begin
      for (int i = N - 1; i >= 0; i--)
        if (pending[i]) prio_idx = W'(i);
    end else begin
      for (int i = 0; i < N; i++)
        if (pending[i]) prio_idx = W'(i);
    end
  end

  // Load decision, pending next-state and lost-event detection
  always_comb begin
    load      = (!out_valid || out_ready) && (|pending);
    load_mask = '0;
    if (load) load_mask[prio_idx] = 1'b1;
    // a capture on the bit being loaded re-pends it instead of being lost
    pending_next  = (pending & ~load_mask) | cap;
    overflow_next = EDGE ? (|(cap & pending & ~load_mask)) : 1'b0;
  end

  // Pending mask and overflow pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= pending_next;
      overflow <= overflow_next;
    end
  end

  // Output register FSM: IDLE has nothing to offer, HOLD presents out_idx until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out_idx   <= prio_idx;
          end
        end
        HOLD: begin
          if (load) begin
            out_idx <= prio_idx;
          end else if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
